bit_serial_lerp: RTL and testbench

- Parametrised bit-serial smoothing datapath: y <= (y*d + x*(2^W - d)) >> W, i.e. a first-order IIR / linear interpolation with a fractional coefficient d.
- Both products are built by one serial shift-add multiplier, one multiplier bit per clock, then summed.
- Next-generation replacement for the fixed 8-bit instruction-driven bit-serial unit: width is generic, operand capture is explicit, and a start/busy/done handshake replaces program-counter stepping.

---
 rtl/bit_serial_lerp_pkg.sv | 18 +
 rtl/bit_serial_lerp_mul.sv | 38 +++
 rtl/bit_serial_lerp.sv | 120 ++++++++++++
 tb/tb_bit_serial_lerp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_lerp_pkg.sv
// Shared types and sizing helpers for the bit-serial lerp datapath.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL_Y,
        MUL_X,
        ADD
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must reach WIDTH (the extra bit of 2^W - d).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_serial_lerp_mul.sv
// Shift-add step unit: one multiplier bit per enabled cycle into a 2W-bit accumulator.
module bit_serial_mul
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               mul_bit,
    input  logic [CW-1:0]      bit_idx,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic [WIDTH:0]     acc_hi
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;

    always_comb begin
        addend = {{WIDTH{1'b0}}, multiplicand} << bit_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en && mul_bit) begin
            acc <= acc + addend;
        end
    end

    // Only the bits that survive the >>W (plus the rounding bit) leave the unit.
    assign acc_hi = acc[2*WIDTH-1:WIDTH-1];

endmodule

// File: rtl/bit_serial_lerp.sv
// Bit-serial first-order smoother: y <= (y*d + x*(2^W - d)) >> W.
// Define BIT_SERIAL_LERP_ROUND_EN for round-half-up instead of truncation.
module bit_serial_lerp
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_y
);

    localparam int CW = cnt_width(WIDTH);

`ifdef BIT_SERIAL_LERP_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] y_r;

    logic [WIDTH:0]   coef_c;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH:0]   mask_c;
    logic             mul_bit;
    logic             mul_en;
    logic             mul_clr;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] res;

    always_comb begin
        coef_c       = {1'b1, {WIDTH{1'b0}}} - {1'b0, d_r};
        mask_d       = WIDTH'(1) << cnt;
        mask_c       = (WIDTH+1)'(1) << cnt;
        mul_en       = (state == MUL_Y) || (state == MUL_X);
        mul_clr      = (state == IDLE) && i_start && !i_load;
        multiplicand = (state == MUL_Y) ? y_r : x_r;
        mul_bit      = (state == MUL_Y) ? |(d_r & mask_d) : |(coef_c & mask_c);
        // Adding 2^(W-1) then shifting equals carrying acc[W-1] into the upper half.
        res          = acc_hi[WIDTH:1] + WIDTH'(acc_hi[0] & RND);
    end

    bit_serial_mul #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_mul (
        .clk          (i_clk),
        .rst          (i_rst),
        .clr          (mul_clr),
        .en           (mul_en),
        .mul_bit      (mul_bit),
        .bit_idx      (cnt),
        .multiplicand (multiplicand),
        .acc_hi       (acc_hi)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            x_r    <= '0;
            d_r    <= '0;
            y_r    <= '0;
            o_y    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_load) begin
                        o_y <= i_x;
                    end else if (i_start) begin
                        x_r   <= i_x;
                        d_r   <= i_d;
                        y_r   <= o_y;
                        cnt   <= '0;
                        state <= MUL_Y;
                    end
                end
                MUL_Y: begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= MUL_X;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MUL_X: begin
                    if (cnt == CW'(WIDTH)) begin
                        cnt   <= '0;
                        state <= ADD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ADD: begin
                    o_y    <= res;
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_bit_serial_lerp.sv
// Directed and randomized checks of bit_serial_lerp (WIDTH=8) against an arithmetic model.
module tb_bit_serial_lerp;

    localparam int W   = 8;
    localparam int LAT = 2 * W + 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic         load;
    logic [W-1:0] x;
    logic [W-1:0] d;
    logic         busy;
    logic         done;
    logic [W-1:0] y;

    int checks;
    int errors;
    int y_model;

    bit_serial_lerp #(
        .WIDTH (W)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_load  (load),
        .i_x     (x),
        .i_d     (d),
        .o_busy  (busy),
        .o_done  (done),
        .o_y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lerp_ref(input int yv, input int xv, input int dv);
        int total;
        total = yv * dv + xv * ((1 << W) - dv);
`ifdef BIT_SERIAL_LERP_ROUND_EN
        total = total + (1 << (W - 1));
`endif
        return total / (1 << W);
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        load = 1'b1;
        x    = W'(v);
        @(posedge clk);
        #1;
        load = 1'b0;
        y_model = v;
        check("load_y", int'(y), v);
    endtask

    task automatic do_start(input string tag, input int xv, input int dv);
        int lat;
        int expected;
        expected = lerp_ref(y_model, xv, dv);
        @(negedge clk);
        start = 1'b1;
        x     = W'(xv);
        d     = W'(dv);
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = W'($urandom);
        d     = W'($urandom);
        check({tag, "_busy"}, int'(busy), 1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_y"}, int'(y), expected);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        y_model = expected;
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, int'(done), 0);
    endtask

    initial begin
        int dones;
        int xv;
        int dv;
        checks  = 0;
        errors  = 0;
        y_model = 0;
        rst     = 1'b1;
        start   = 1'b0;
        load    = 1'b0;
        x       = '0;
        d       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-clock clears state with no edge.
        do_load(77);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_y", int'(y), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        y_model = 0;
        @(negedge clk);
        rst = 1'b0;

        do_load(200);
        check("load_done", int'(done), 0);
        check("load_busy", int'(busy), 0);

        do_load(201);
        do_start("round", 100, 128);
`ifdef BIT_SERIAL_LERP_ROUND_EN
        check("round_const", int'(y), 151);
`else
        check("round_const", int'(y), 150);
`endif

        do_load(50);
        do_start("d0", 255, 0);
        check("d0_const", int'(y), 255);
        do_load(255);
        do_start("d255", 0, 255);
        check("d255_const", int'(y), 254);

        // Start/load/operand changes while busy must be ignored.
        do_load(200);
        @(negedge clk);
        start = 1'b1;
        x     = 8'd100;
        d     = 8'd64;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (n == 5) begin
                start = 1'b1;
                x     = 8'd7;
                d     = 8'd3;
            end
            if (n == 6) begin
                start = 1'b0;
                load  = 1'b1;
                x     = 8'd9;
            end
            if (n == 7) load = 1'b0;
            if (n == LAT) check("busy_done_edge", int'(done), 1);
        end
        check("busy_one_done", dones, 1);
        check("busy_y", int'(y), 125);
        y_model = 125;

        // Reset mid-operation abandons the update.
        @(negedge clk);
        start = 1'b1;
        x     = 8'd180;
        d     = 8'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_y", int'(y), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        y_model = 0;
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_y_hold", int'(y), 0);
        do_load(100);
        do_start("after_rst", 100, 128);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 255)));
            xv = int'($urandom_range(0, 255));
            dv = int'($urandom_range(0, 255));
            do_start("rand", xv, dv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
